// File: rtl/prog_loader.sv
// Program-transfer loader: drains bytes from uart_mux, packs them high-byte-first into
// 16-bit words, writes them to instruction memory and stops on an aligned 7F FF terminator.
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_recv,
    input  logic                  rx_full,
    input  logic [7:0]            rx_data,
    output logic                  rd,
    output logic                  end_prog_recv,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        HI_GAP,
        LO,
        LO_GAP,
        COMMIT,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(IMEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

    state_t      state;
    logic [7:0]  hi_byte;
    logic [7:0]  lo_byte;
    logic [15:0] word;

    assign word = {hi_byte, lo_byte};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            hi_byte       <= '0;
            lo_byte       <= '0;
            rd            <= 1'b0;
            end_prog_recv <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            cpu_hold      <= 1'b0;
            word_count    <= '0;
            overflow      <= 1'b0;
        end else begin
            rd            <= 1'b0;
            end_prog_recv <= 1'b0;
            imem_we       <= 1'b0;
            case (state)
                IDLE: begin
                    if (prog_recv) begin
                        word_count <= '0;
                        imem_addr  <= '0;
                        overflow   <= 1'b0;
                        cpu_hold   <= 1'b1;
                        state      <= HI;
                    end
                end
                DONE: begin
                    if (!prog_recv) begin
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    // Abort takes priority over byte capture and commit; partial word is dropped.
                    if (!prog_recv) begin
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        case (state)
                            HI: begin
                                if (rx_full) begin
                                    hi_byte <= rx_data;
                                    rd      <= 1'b1;
                                    state   <= HI_GAP;
                                end
                            end
                            HI_GAP: state <= LO;
                            LO: begin
                                if (rx_full) begin
                                    lo_byte <= rx_data;
                                    rd      <= 1'b1;
                                    state   <= LO_GAP;
                                end
                            end
                            LO_GAP: state <= COMMIT;
                            COMMIT: begin
                                if (word == 16'h7FFF) begin
                                    end_prog_recv <= 1'b1;
                                    state         <= DONE;
                                end else if (word_count < DEPTH) begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= word_count[ADDR_WIDTH-1:0];
                                    imem_wdata <= word;
                                    word_count <= word_count + ONE;
                                    state      <= HI;
                                end else begin
                                    overflow <= 1'b1;
                                    state    <= HI;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a UART byte source, a write monitor, and a
// word-level reference model that predicts writes, word_count and overflow per load.
module tb_prog_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_recv;
    logic          rx_full;
    logic [7:0]    rx_data;
    logic          rd;
    logic          end_prog_recv;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_hold;
    logic [AW:0]   word_count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int rd_count  = 0;
    int end_count = 0;

    logic [7:0]     byte_q[$];
    logic [AW+15:0] exp_q[$];
    logic           drop_byte = 1'b0;
    logic           prev_end  = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(AW), .IMEM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .prog_recv     (prog_recv),
        .rx_full       (rx_full),
        .rx_data       (rx_data),
        .rd            (rd),
        .end_prog_recv (end_prog_recv),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_hold      (cpu_hold),
        .word_count    (word_count),
        .overflow      (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // UART source: presents one byte at a time and clears rx_full once it is read.
    initial begin
        rx_full = 1'b0;
        rx_data = '0;
        forever begin
            @(negedge clk);
            if (rd) begin
                chk("rd_with_rx_full", rx_full, 1);
                rd_count++;
                rx_full = 1'b0;
            end else if (drop_byte) begin
                rx_full = 1'b0;
            end else if (!rx_full && byte_q.size() > 0 && $urandom_range(0, 1) == 0) begin
                rx_data = byte_q.pop_front();
                rx_full = 1'b1;
            end
        end
    end

    // Write / terminator monitor.
    always @(negedge clk) begin : monitor
        logic [AW+15:0] e;
        if (imem_we) begin
            chk("rd_we_exclusive", rd, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", imem_addr, e[AW+15:16]);
                chk("write_data", imem_wdata, e[15:0]);
            end
        end
        if (end_prog_recv) begin
            chk("end_pulse_width", prev_end, 0);
            end_count++;
        end
        prev_end = end_prog_recv;
    end

    // Reference model: pairs bytes into words, stops at an aligned 7FFF, caps writes at DEPTH.
    task automatic model_load(input logic [7:0] b[$], output int wc, output bit ovf);
        logic [15:0] w;
        wc  = 0;
        ovf = 1'b0;
        for (int unsigned i = 0; i + 1 < b.size(); i += 2) begin
            w = {b[i], b[i+1]};
            if (w == 16'h7FFF) break;
            if (wc < DEPTH) begin
                exp_q.push_back({AW'(wc), w});
                wc++;
            end else begin
                ovf = 1'b1;
            end
        end
    endtask

    task automatic wait_drained(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (byte_q.size() == 0 && !rx_full) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_drain_timeout"}, 1, 0);
    endtask

    task automatic run_load(input logic [7:0] b[$], input string tag);
        int wc;
        bit ovf;
        int rd0;
        int end0;
        model_load(b, wc, ovf);
        rd0  = rd_count;
        end0 = end_count;
        @(negedge clk);
        prog_recv = 1'b1;
        @(negedge clk);
        chk({tag, "_start_hold"}, cpu_hold, 1);
        chk({tag, "_start_ovf_clear"}, overflow, 0);
        foreach (b[i]) byte_q.push_back(b[i]);
        for (int k = 0; k < 3000 && end_count == end0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({tag, "_end_pulses"}, end_count - end0, 1);
        chk({tag, "_word_count"}, word_count, wc);
        chk({tag, "_overflow"}, overflow, ovf);
        chk({tag, "_hold_done"}, cpu_hold, 1);
        chk({tag, "_rd_pulses"}, rd_count - rd0, b.size());
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        prog_recv = 1'b0;
        @(negedge clk);
        chk({tag, "_hold_release"}, cpu_hold, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b[$];
        int rd0;
        int end0;
        int wc;
        bit ovf;
        logic [15:0] w;

        rst       = 1'b0;
        prog_recv = 1'b0;
        #12;
        chk("reset_rd", rd, 0);
        chk("reset_end", end_prog_recv, 0);
        chk("reset_we", imem_we, 0);
        chk("reset_hold", cpu_hold, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_addr", imem_addr, 0);
        chk("reset_wdata", imem_wdata, 0);
        chk("reset_wc", word_count, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        b = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h7F, 8'hFF};
        run_load(b, "basic");

        b = '{8'h01, 8'h7F, 8'hFF, 8'h02, 8'h7F, 8'hFF};
        run_load(b, "unaligned");

        b = '{};
        for (int i = 0; i < DEPTH + 2; i++) begin
            b.push_back(8'(i + 1));
            b.push_back(8'h5A);
        end
        b.push_back(8'h7F);
        b.push_back(8'hFF);
        run_load(b, "ovf");

        b = '{8'hC0, 8'hDE, 8'h7F, 8'hFF};
        run_load(b, "after_ovf");

        for (int n = 0; n < 8; n++) begin
            b = '{};
            for (int i = 0; i < int'($urandom_range(0, DEPTH + 3)); i++) begin
                w = 16'($urandom_range(0, 16'hFFFF));
                if (w == 16'h7FFF) w = 16'h1234;
                b.push_back(w[15:8]);
                b.push_back(w[7:0]);
            end
            b.push_back(8'h7F);
            b.push_back(8'hFF);
            run_load(b, "rand");
        end

        // Abort with a dangling high byte.
        b = '{8'h12, 8'h34, 8'h56};
        model_load(b, wc, ovf);
        rd0  = rd_count;
        end0 = end_count;
        @(negedge clk);
        prog_recv = 1'b1;
        foreach (b[i]) byte_q.push_back(b[i]);
        wait_drained("abort");
        repeat (3) @(negedge clk);
        prog_recv = 1'b0;
        @(negedge clk);
        chk("abort_hold", cpu_hold, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_end", end_count - end0, 0);
        chk("abort_wc", word_count, wc);
        chk("abort_rd_pulses", rd_count - rd0, 3);
        chk("abort_writes_left", exp_q.size(), 0);

        // Idle isolation: a byte arriving outside transfer mode is never read.
        rd0 = rd_count;
        byte_q.push_back(8'h61);
        repeat (12) @(negedge clk);
        chk("idle_rx_full", rx_full, 1);
        chk("idle_no_rd", rd_count - rd0, 0);
        drop_byte = 1'b1;
        repeat (2) @(negedge clk);
        drop_byte = 1'b0;
        @(negedge clk);

        // Asynchronous reset between high and low byte.
        b = '{8'h11, 8'h11, 8'h22, 8'h22, 8'hA5};
        model_load(b, wc, ovf);
        @(negedge clk);
        prog_recv = 1'b1;
        foreach (b[i]) byte_q.push_back(b[i]);
        wait_drained("areset");
        @(negedge clk);
        chk("areset_pre_wc", word_count, wc);
        chk("areset_pre_hold", cpu_hold, 1);
        #2;
        rst       = 1'b0;
        prog_recv = 1'b0;
        #1;
        chk("areset_hold", cpu_hold, 0);
        chk("areset_wc", word_count, 0);
        chk("areset_addr", imem_addr, 0);
        chk("areset_wdata", imem_wdata, 0);
        chk("areset_we", imem_we, 0);
        chk("areset_rd", rd, 0);
        chk("areset_end", end_prog_recv, 0);
        chk("areset_ovf", overflow, 0);
        chk("areset_writes_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        b = '{8'hBE, 8'hEF, 8'h7F, 8'hFF};
        run_load(b, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Downstream consumer of uart_mux's receive side during program-transfer mode.
- While prog_recv=1 it drains received bytes, assembles 16-bit instruction words (high byte first) and writes them sequentially into instruction memory from address 0.
- Detects the word-aligned terminator 7F FF and pulses end_prog_recv back to uart_mux.
- Holds the CPU in reset for the whole load.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word address width.
- IMEM_DEPTH, 1024, number of writable words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- prog_recv  in  1  program-transfer mode flag from uart_mux
- rx_full  in  1  uart_mux holds an unread byte
- rx_data  in  8  byte from uart_mux, valid while rx_full=1
- rd  out  1  one-cycle read strobe to uart_mux; clears rx_full at the next edge
- end_prog_recv  out  1  one-cycle pulse; terminator received
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_addr  out  ADDR_WIDTH  write word address
- imem_wdata  out  16  write word, {high byte, low byte}
- cpu_hold  out  1  keeps the CPU in reset while a load is active
- word_count  out  ADDR_WIDTH+1  words written in the current or last load
- overflow  out  1  sticky: a word was dropped because the address reached IMEM_DEPTH

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - rd, end_prog_recv, imem_we, cpu_hold, overflow = 0.
  - imem_addr, imem_wdata, word_count = 0.
  - Byte latch cleared.
- States: IDLE, HI, HI_GAP, LO, LO_GAP, COMMIT, DONE.
- IDLE:
  - On the cycle prog_recv is seen 1: clear word_count, imem_addr and overflow; set cpu_hold=1; go to HI.
  - Any byte present while in IDLE is ignored (never read).
- HI: if rx_full=1, latch rx_data as the high byte, assert rd for exactly the next cycle, go to HI_GAP.
- HI_GAP: one-cycle guard so the same byte is never consumed twice (rx_full drops the edge after rd). Go to LO.
- LO: if rx_full=1, latch the low byte, pulse rd, go to LO_GAP.
- LO_GAP: go to COMMIT.
- COMMIT, evaluated in one cycle:
  - If word == 16'h7FFF: no write; end_prog_recv=1 for one cycle; go to DONE.
  - Else if word_count < IMEM_DEPTH: imem_we=1 this cycle with imem_addr=word_count and imem_wdata=word; word_count+1; go to HI.
  - Else: no write; overflow=1 (sticky); word_count unchanged; go to HI.
- Terminator check is word-aligned only:
  - Bytes 7F FF split across words are data, e.g. xx 7F FF yy gives words xx7F and FFyy.
  - 7F FF as a normal data word is impossible by protocol.
- DONE:
  - cpu_hold stays 1 until prog_recv is seen 0, then cpu_hold=0 and go to IDLE.
  - word_count and overflow hold their values.
- Abort: prog_recv seen 0 in any of HI..COMMIT:
  - Go to IDLE immediately and drop any partial word.
  - No write that cycle; no end_prog_recv; cpu_hold=0.
  - Words already written stay written.
- Simultaneous events:
  - Abort wins over byte capture and COMMIT.
  - rd is never asserted while rx_full=0.
  - rd and imem_we are never asserted in the same cycle.
- Throughput: at most one byte per 2 cycles, well above UART rate; rx_full never overruns because of this block.
- Reset mid-load: everything returns to reset values; cpu_hold drops at once.

Test Plan:
- Basic load: reset, raise prog_recv, send 12 34 AB CD 7F FF.
  - Writes 0x1234@0 then 0xABCD@1.
  - end_prog_recv pulses once, 1 cycle wide; word_count=2.
  - cpu_hold stays 1 until prog_recv drops, then 0.
  - Exactly 6 rd pulses, none with rx_full=0.
- Unaligned terminator: send 01 7F FF 02 7F FF.
  - Writes 0x017F@0, 0xFF02@1.
  - end_prog_recv only after the last pair; word_count=2.
- Overflow: IMEM_DEPTH=2, send words 1111 2222 3333 then 7FFF.
  - Two writes only; overflow=1; word_count=2; end_prog_recv pulses.
  - Next load start clears overflow.
- Abort: send 12 34 56, then prog_recv=0.
  - One write 0x1234@0; byte 56 discarded.
  - No end_prog_recv; cpu_hold=0 within 1 cycle.
- Idle isolation: prog_recv=0, uart delivers 61.
  - rd stays 0; rx_full stays 1; no imem_we.
- Async reset: assert rst=0 between high and low byte.
  - All outputs zero immediately, without a clock edge.
  - After release, a new load starts at address 0.
